// File: rtl/seq_gen_pkg.sv
// Shared state encoding and parameter defaults for the serial pattern generator.
package seq_gen_pkg;

  localparam int   PAT_W_DEF      = 4;
  localparam int   CNT_W_DEF      = 4;
  localparam int   GAP_W_DEF      = 3;
  localparam logic IDLE_LEVEL_DEF = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_GAP   = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/seq_bit_serializer.sv
// Shift register plus bit counter; presents the current MSB and the bit that follows it.
module seq_bit_serializer
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [PAT_W-1:0] pattern,
  output logic             msb,
  output logic             msb_next,
  output logic             last_bit
);

  localparam int BC_W = $clog2(PAT_W);
  localparam logic [BC_W-1:0] LAST = BC_W'(PAT_W - 1);

  logic [PAT_W-1:0] sr;
  logic [BC_W-1:0]  cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= pattern;
      cnt <= '0;
    end else if (shift_en) begin
      sr  <= {sr[PAT_W-2:0], 1'b0};
      cnt <= (cnt == LAST) ? '0 : cnt + BC_W'(1);
    end
  end

  assign msb      = sr[PAT_W-1];
  assign msb_next = sr[PAT_W-2];
  assign last_bit = (cnt == LAST);

endmodule

// File: rtl/seq_pattern_generator.sv
// Serial pattern transmitter: repeats a latched pattern MSB-first with optional idle gaps.
// Handshake: start is a request taken only when busy=0 (IDLE or DONE); there is no back-pressure.
module seq_pattern_generator
  import seq_gen_pkg::*;
#(
  parameter int   PAT_W      = PAT_W_DEF,
  parameter int   CNT_W      = CNT_W_DEF,
  parameter int   GAP_W      = GAP_W_DEF,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] bursts,
  input  logic [GAP_W-1:0] gap_len,
  output logic             seq_out,
  output logic             seq_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  state_t           state, state_d;
  logic [PAT_W-1:0] pat_q, pat_d, load_pat;
  logic [CNT_W-1:0] burst_cnt, burst_d;
  logic [GAP_W-1:0] gap_q, gap_len_d, gap_cnt, gap_cnt_d;
  logic             load, shift_en;
  logic             ser_msb, ser_msb_next, last_bit;
  logic             seq_out_d;

  seq_bit_serializer #(.PAT_W(PAT_W)) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift_en (shift_en),
    .pattern  (load_pat),
    .msb      (ser_msb),
    .msb_next (ser_msb_next),
    .last_bit (last_bit)
  );

  always_comb begin
    state_d   = state;
    pat_d     = pat_q;
    burst_d   = burst_cnt;
    gap_len_d = gap_q;
    gap_cnt_d = gap_cnt;
    load      = 1'b0;
    shift_en  = 1'b0;
    load_pat  = pat_q;
    case (state)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          pat_d     = pattern;
          burst_d   = bursts;
          gap_len_d = gap_len;
          load_pat  = pattern;
          if (bursts != '0) begin
            state_d = ST_SHIFT;
            load    = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        // Shifting on the last bit too lets the bit counter wrap back to 0.
        if (last_bit) begin
          burst_d = burst_cnt - CNT_W'(1);
          if (burst_cnt == CNT_W'(1)) begin
            state_d  = ST_DONE;
            shift_en = 1'b1;
          end else if (gap_q == '0) begin
            load = 1'b1;
          end else begin
            state_d   = ST_GAP;
            gap_cnt_d = gap_q;
            shift_en  = 1'b1;
          end
        end else begin
          shift_en = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_W'(1)) begin
          state_d   = ST_SHIFT;
          load      = 1'b1;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt - GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    seq_out_d = IDLE_LEVEL;
    if (state_d == ST_SHIFT) seq_out_d = load ? load_pat[PAT_W-1] : ser_msb_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      pat_q     <= '0;
      burst_cnt <= '0;
      gap_q     <= '0;
      gap_cnt   <= '0;
      seq_out   <= IDLE_LEVEL;
      seq_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      pat_q     <= pat_d;
      burst_cnt <= burst_d;
      gap_q     <= gap_len_d;
      gap_cnt   <= gap_cnt_d;
      seq_out   <= seq_out_d;
      seq_valid <= (state_d == ST_SHIFT);
      busy      <= (state_d == ST_SHIFT) || (state_d == ST_GAP);
      done      <= (state_d == ST_DONE);
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_seq_pattern_generator.sv
// Self-checking bench: a per-cycle expected queue built from the transfer rules, driven by directed and random starts.
module tb_seq_pattern_generator;

  localparam int PAT_W = 4;
  localparam int CNT_W = 4;
  localparam int GAP_W = 3;
  localparam logic [5:0] IDLE_V = 6'b000000;

  logic             clk;
  logic             rst;
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] bursts;
  logic [GAP_W-1:0] gap_len;
  logic             seq_out, seq_valid, busy, done;
  logic [1:0]       dbg_state;

  int total = 0;
  int bad = 0;
  int busy_seen = 0;
  // Entry per cycle: {state[1:0], busy, seq_valid, seq_out, done}
  logic [5:0] exp_q[$];

  seq_pattern_generator #(
    .PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W), .IDLE_LEVEL(1'b0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pattern   (pattern),
    .bursts    (bursts),
    .gap_len   (gap_len),
    .seq_out   (seq_out),
    .seq_valid (seq_valid),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Whole transfer as seen on the outputs, one entry per cycle after the accepting edge.
  task automatic model_push(input logic [PAT_W-1:0] p, input int b, input int g);
    for (int r = 0; r < b; r++) begin
      if (r > 0)
        for (int i = 0; i < g; i++) exp_q.push_back({2'b10, 1'b1, 1'b0, 1'b0, 1'b0});
      for (int i = PAT_W - 1; i >= 0; i--) exp_q.push_back({2'b01, 1'b1, 1'b1, p[i], 1'b0});
    end
    exp_q.push_back({2'b11, 1'b0, 1'b0, 1'b0, 1'b1});
  endtask

  task automatic step(input string tag, input logic s, input logic [PAT_W-1:0] p,
                      input logic [CNT_W-1:0] b, input logic [GAP_W-1:0] g);
    logic [5:0] exp_v;
    @(negedge clk);
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_V;
    check(tag, {26'd0, dbg_state, busy, seq_valid, seq_out, done}, {26'd0, exp_v});
    if (busy) busy_seen++;
    start = s; pattern = p; bursts = b; gap_len = g;
    if (s && rst && !exp_v[3]) model_push(p, int'(b), int'(g));
  endtask

  task automatic idle_steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, '0, '0, '0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; pattern = '0; bursts = '0; gap_len = '0;

    idle_steps("reset", 3);
    rst = 1'b1;
    idle_steps("idle", 10);

    step("single", 1'b1, 4'b1011, 4'd1, 3'd0);
    idle_steps("single", 7);

    step("b2b", 1'b1, 4'b1011, 4'd2, 3'd0);
    idle_steps("b2b", 11);

    step("gap", 1'b1, 4'b1100, 4'd3, 3'd2);
    busy_seen = 0;
    idle_steps("gap", 18);
    check("gap_busy_cycles", busy_seen, 16);

    step("zero_bursts", 1'b1, 4'b1111, 4'd0, 3'd3);
    idle_steps("zero_bursts", 3);

    step("hold_start", 1'b1, 4'b1001, 4'd2, 3'd1);
    for (int i = 0; i < 12; i++) step("hold_start", 1'b1, 4'b0110, 4'd1, 3'd0);
    idle_steps("hold_start", 6);

    step("start_in_done", 1'b1, 4'b1011, 4'd1, 3'd0);
    idle_steps("start_in_done", 4);
    step("start_in_done", 1'b1, 4'b0110, 4'd1, 3'd0);
    idle_steps("start_in_done", 7);

    step("max_bursts", 1'b1, 4'b1010, 4'd15, 3'd0);
    idle_steps("max_bursts", 64);

    // Abort during bit 3 of the second burst.
    step("mid_reset", 1'b1, 4'b1011, 4'd2, 3'd0);
    idle_steps("mid_reset", 7);
    #1 rst = 1'b0;
    #1 check("async_reset", {26'd0, dbg_state, busy, seq_valid, seq_out, done}, 32'd0);
    exp_q.delete();
    idle_steps("mid_reset_hold", 2);
    rst = 1'b1;
    idle_steps("mid_reset_after", 3);
    step("fresh_single", 1'b1, 4'b1011, 4'd1, 3'd0);
    idle_steps("fresh_single", 7);

    for (int i = 0; i < 1500; i++) begin
      logic [CNT_W-1:0] b;
      b = ($urandom_range(0, 15) == 0) ? CNT_W'($urandom_range(0, 15)) : CNT_W'($urandom_range(0, 3));
      step("random", ($urandom_range(0, 3) == 0), PAT_W'($urandom), b, GAP_W'($urandom_range(0, 7)));
    end
    idle_steps("drain", 120);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
